memfifo_data_emulator: RTL and testbench
========================================

Name: memfifo_data_emulator

Overview:
- Emulates the DDR memory-FIFO side of a Data_Request, so the serializer read path can be exercised without DDR.
- On a request strobe it waits a programmable fetch latency, then raises memfifo_data_ready and presents the packet count.
- It then returns one deterministic data word per memfifo_re pulse until all words are consumed.
- It drives the enable/packet_no inputs of the read-enable generator and consumes that generator's memfifo_re.

Parameters:
- DATA_WIDTH, 64, width of memfifo_data; must be at least 64.
- WORDS_PER_PKT, 2, number of memfifo_re reads per packet.
- FETCH_DELAY, 20, clock cycles from accepted request to memfifo_data_ready; must be at least 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- data_req  in  1  request strobe, synchronous to clk; rising edge starts a transfer.
- req_tag  in  16  event tag, sampled with the accepted request.
- req_packet_no  in  16  number of packets to serve, sampled with the accepted request.
- memfifo_re  in  1  one-cycle read strobe from the consumer.
- memfifo_data_ready  out  1  level: data available; drives the generator's enable.
- memfifo_packet_no  out  16  latched packet count; stable whenever memfifo_data_ready=1.
- memfifo_data  out  DATA_WIDTH  read data word.
- memfifo_data_valid  out  1  one-cycle pulse marking a fresh memfifo_data word.
- xfer_done  out  1  one-cycle pulse when the transfer completes.
- err_underrun  out  1  sticky flag: memfifo_re arrived with no word available.
- err_busy_req  out  1  sticky flag: request edge arrived while not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Assertion mid-transfer aborts immediately.
- The request edge is data_req & ~data_req_d, using a registered copy of data_req.
- States:
  - IDLE: on a request edge, latch req_tag and req_packet_no, load words_left = req_packet_no*WORDS_PER_PKT (18-bit unsigned), clear the word counter, go to FETCH.
  - FETCH: count FETCH_DELAY cycles, then go to READY. Entering READY sets memfifo_data_ready=1 and memfifo_packet_no=latched count in the same edge.
  - READY: each memfifo_re with words_left>0 decrements words_left and registers a data word. The word and memfifo_data_valid=1 appear exactly 1 cycle after the re. When words_left reaches 0, the same edge clears memfifo_data_ready, pulses xfer_done, and goes to IDLE.
- Zero packets: req_packet_no=0 goes FETCH then READY for exactly one cycle (memfifo_data_ready high 1 cycle, memfifo_packet_no=0). xfer_done pulses as ready falls, then IDLE.
- Data word layout:
  - [63:48] latched tag.
  - [47:32] packet index, 0-based.
  - [31:16] word index within the packet.
  - [15:0] running word count, 0-based.
  - Bits above 63 are zero.
- Packet index increments and word index wraps to 0 after WORDS_PER_PKT words.
- memfifo_re in IDLE or FETCH, or in READY with words_left=0, sets err_underrun.
  - No data_valid pulse; memfifo_data holds its previous value.
- A request edge outside IDLE sets err_busy_req and is otherwise ignored. The latched values do not change.
- Sticky errors clear only on reset.
- Back-to-back re on consecutive cycles are served at 1 word/cycle.
- memfifo_data holds its last value between reads.
- memfifo_packet_no holds its value after the transfer until the next accepted request.

Test Plan:
- Reset, tag=16'h00A5, packet_no=3, request; consumer issues one re every 9 cycles. Required:
  - memfifo_data_ready rises exactly FETCH_DELAY cycles after the edge is registered.
  - 6 words, each valid 1 cycle after its re, first word 64'h00A5_0000_0000_0000, last word 64'h00A5_0002_0001_0005.
  - Ready falls and xfer_done pulses on the 6th re edge; no error flags set.
- packet_no=0 -> ready high exactly 1 cycle with memfifo_packet_no=0; xfer_done pulses; no data_valid; no errors.
- packet_no=2, consecutive re on 4 cycles -> 4 data_valid pulses on consecutive cycles with word counts 0..3; ready low after the 4th re.
- Extra re after completion, and one re during FETCH -> err_underrun=1; no data_valid; memfifo_data unchanged.
- Second request edge during FETCH -> err_busy_req=1; the original packet_no and tag are still served intact.
- rst_n low during READY after 2 of 6 words, then a new request with packet_no=1 -> all outputs 0 during reset; the new transfer serves 2 words starting at running word count 0 with the new tag.

Source files
------------

// File: rtl/memfifo_data_emulator.sv
// Stands in for the DDR memory FIFO behind a Data_Request: after a fixed fetch latency it
// announces a packet count and returns one deterministic, self-describing word per read strobe.
module memfifo_data_emulator #(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned WORDS_PER_PKT = 2,
   parameter int unsigned FETCH_DELAY   = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  data_req,
   input  logic [15:0]           req_tag,
   input  logic [15:0]           req_packet_no,
   input  logic                  memfifo_re,
   output logic                  memfifo_data_ready,
   output logic [15:0]           memfifo_packet_no,
   output logic [DATA_WIDTH-1:0] memfifo_data,
   output logic                  memfifo_data_valid,
   output logic                  xfer_done,
   output logic                  err_underrun,
   output logic                  err_busy_req
);

   localparam int unsigned FetchCntW = (FETCH_DELAY > 1) ? $clog2(FETCH_DELAY) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StReady
   } state_e;

   state_e                state_q, state_d;
   logic                  req_dly_q;
   logic [15:0]           tag_q, tag_d;
   logic [15:0]           pkt_lat_q, pkt_lat_d;
   logic [17:0]           words_left_q, words_left_d;
   logic [FetchCntW-1:0]  fetch_cnt_q, fetch_cnt_d;
   logic [15:0]           pkt_idx_q, pkt_idx_d;
   logic [15:0]           word_idx_q, word_idx_d;
   logic [15:0]           word_cnt_q, word_cnt_d;
   logic                  ready_q, ready_d;
   logic [15:0]           pkt_out_q, pkt_out_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  err_ur_q, err_ur_d;
   logic                  err_busy_q, err_busy_d;

   logic                  req_edge;
   logic [DATA_WIDTH-1:0] word;

   assign req_edge = data_req & ~req_dly_q;

   // Word contents identify tag, packet, word-in-packet and running count for easy checking.
   always_comb begin
      word       = '0;
      word[63:0] = {tag_q, pkt_idx_q, word_idx_q, word_cnt_q};
   end

   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      pkt_lat_d    = pkt_lat_q;
      words_left_d = words_left_q;
      fetch_cnt_d  = fetch_cnt_q;
      pkt_idx_d    = pkt_idx_q;
      word_idx_d   = word_idx_q;
      word_cnt_d   = word_cnt_q;
      ready_d      = ready_q;
      pkt_out_d    = pkt_out_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      done_d       = 1'b0;
      err_ur_d     = err_ur_q;
      err_busy_d   = err_busy_q;

      case (state_q)
         StIdle: begin
            if (req_edge) begin
               tag_d        = req_tag;
               pkt_lat_d    = req_packet_no;
               words_left_d = 18'(req_packet_no) * 18'(WORDS_PER_PKT);
               fetch_cnt_d  = '0;
               pkt_idx_d    = '0;
               word_idx_d   = '0;
               word_cnt_d   = '0;
               state_d      = StFetch;
            end
            if (memfifo_re) begin
               err_ur_d = 1'b1;
            end
         end

         StFetch: begin
            if (fetch_cnt_q == FetchCntW'(FETCH_DELAY - 1)) begin
               state_d   = StReady;
               ready_d   = 1'b1;
               pkt_out_d = pkt_lat_q;
            end else begin
               fetch_cnt_d = fetch_cnt_q + FetchCntW'(1);
            end
            if (req_edge) begin
               err_busy_d = 1'b1;
            end
            if (memfifo_re) begin
               err_ur_d = 1'b1;
            end
         end

         StReady: begin
            if (req_edge) begin
               err_busy_d = 1'b1;
            end
            if (words_left_q == '0) begin
               // Zero-packet request: ready stays up for this single cycle only.
               state_d = StIdle;
               ready_d = 1'b0;
               done_d  = 1'b1;
               if (memfifo_re) begin
                  err_ur_d = 1'b1;
               end
            end else if (memfifo_re) begin
               words_left_d = words_left_q - 18'd1;
               data_d       = word;
               valid_d      = 1'b1;
               word_cnt_d   = word_cnt_q + 16'd1;
               if (word_idx_q == 16'(WORDS_PER_PKT - 1)) begin
                  word_idx_d = '0;
                  pkt_idx_d  = pkt_idx_q + 16'd1;
               end else begin
                  word_idx_d = word_idx_q + 16'd1;
               end
               if (words_left_q == 18'd1) begin
                  state_d = StIdle;
                  ready_d = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = StIdle;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         req_dly_q    <= 1'b0;
         tag_q        <= '0;
         pkt_lat_q    <= '0;
         words_left_q <= '0;
         fetch_cnt_q  <= '0;
         pkt_idx_q    <= '0;
         word_idx_q   <= '0;
         word_cnt_q   <= '0;
         ready_q      <= 1'b0;
         pkt_out_q    <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         err_ur_q     <= 1'b0;
         err_busy_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_dly_q    <= data_req;
         tag_q        <= tag_d;
         pkt_lat_q    <= pkt_lat_d;
         words_left_q <= words_left_d;
         fetch_cnt_q  <= fetch_cnt_d;
         pkt_idx_q    <= pkt_idx_d;
         word_idx_q   <= word_idx_d;
         word_cnt_q   <= word_cnt_d;
         ready_q      <= ready_d;
         pkt_out_q    <= pkt_out_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         err_ur_q     <= err_ur_d;
         err_busy_q   <= err_busy_d;
      end
   end

   assign memfifo_data_ready = ready_q;
   assign memfifo_packet_no  = pkt_out_q;
   assign memfifo_data       = data_q;
   assign memfifo_data_valid = valid_q;
   assign xfer_done          = done_q;
   assign err_underrun       = err_ur_q;
   assign err_busy_req       = err_busy_q;

   a_done_drops_ready : assert property (@(posedge clk) disable iff (!rst_n)
      xfer_done |-> !memfifo_data_ready);

endmodule

// File: tb/tb_memfifo_data_emulator.sv
// Randomized scenario bench for memfifo_data_emulator; expected words and timing come from
// simple arithmetic on read counts and cycle counts.
module tb_memfifo_data_emulator;

   localparam int unsigned DW  = 64;
   localparam int unsigned WPP = 2;
   localparam int unsigned FD  = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          data_req = 1'b0;
   logic [15:0]   req_tag = '0;
   logic [15:0]   req_packet_no = '0;
   logic          memfifo_re = 1'b0;
   logic          memfifo_data_ready;
   logic [15:0]   memfifo_packet_no;
   logic [DW-1:0] memfifo_data;
   logic          memfifo_data_valid;
   logic          xfer_done;
   logic          err_underrun;
   logic          err_busy_req;

   int n_cmp = 0;
   int n_bad = 0;

   memfifo_data_emulator #(
      .DATA_WIDTH   (DW),
      .WORDS_PER_PKT(WPP),
      .FETCH_DELAY  (FD)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .data_req          (data_req),
      .req_tag           (req_tag),
      .req_packet_no     (req_packet_no),
      .memfifo_re        (memfifo_re),
      .memfifo_data_ready(memfifo_data_ready),
      .memfifo_packet_no (memfifo_packet_no),
      .memfifo_data      (memfifo_data),
      .memfifo_data_valid(memfifo_data_valid),
      .xfer_done         (xfer_done),
      .err_underrun      (err_underrun),
      .err_busy_req      (err_busy_req)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // n-th word (0-based running count) of a transfer tagged 'tag'.
   function automatic logic [DW-1:0] exp_word(input logic [15:0] tag, input int unsigned n);
      logic [DW-1:0] w;
      w       = '0;
      w[63:0] = {tag, 16'(n / WPP), 16'(n % WPP), 16'(n)};
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic [15:0] tag, input logic [15:0] pn);
      req_tag       = tag;
      req_packet_no = pn;
      data_req      = 1'b1;
      tick();
      data_req      = 1'b0;
   endtask

   task automatic apply_reset();
      data_req   = 1'b0;
      memfifo_re = 1'b0;
      rst_n      = 1'b0;
      tick();
      tick();
      rst_n      = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      data_req   = 1'b1;
      memfifo_re = 1'b1;
      rst_n      = 1'b0;
      #1;
      n_cmp++;
      if ({memfifo_data_ready, memfifo_packet_no, memfifo_data, memfifo_data_valid, xfer_done,
           err_underrun, err_busy_req} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got ready=%0b pn=%h data=%h valid=%0b done=%0b ur=%0b busy=%0b want all 0",
                  memfifo_data_ready, memfifo_packet_no, memfifo_data, memfifo_data_valid,
                  xfer_done, err_underrun, err_busy_req);
      end
      tick();
      tick();
      n_cmp++;
      if ({memfifo_data_ready, memfifo_data_valid, err_underrun, err_busy_req} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_held: got ready/valid/ur/busy=%b want 0000",
                  {memfifo_data_ready, memfifo_data_valid, err_underrun, err_busy_req});
      end
      data_req   = 1'b0;
      memfifo_re = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      start_req(16'h00A5, 16'd3);
      for (int i = 1; i <= int'(FD); i++) begin
         tick();
         n_cmp++;
         if (memfifo_data_ready !== 1'(i == int'(FD))) begin
            n_bad++;
            $display("FAIL basic_ready_timing: cycle %0d got %0b want %0b", i,
                     memfifo_data_ready, (i == int'(FD)));
         end
      end
      n_cmp++;
      if (memfifo_packet_no !== 16'd3) begin
         n_bad++;
         $display("FAIL basic_packet_no: got %0d want 3", memfifo_packet_no);
      end
      for (int k = 0; k < 6; k++) begin
         repeat (8) begin
            tick();
            n_cmp++;
            if ({memfifo_data_valid, memfifo_data_ready} !== 2'b01) begin
               n_bad++;
               $display("FAIL basic_idle_gap: word %0d valid/ready got %b want 01", k,
                        {memfifo_data_valid, memfifo_data_ready});
            end
         end
         memfifo_re = 1'b1;
         tick();
         memfifo_re = 1'b0;
         n_cmp++;
         if (memfifo_data_valid !== 1'b1 || memfifo_data !== exp_word(16'h00A5, k)) begin
            n_bad++;
            $display("FAIL basic_word: word %0d got valid=%0b data=%h want 1 %h", k,
                     memfifo_data_valid, memfifo_data, exp_word(16'h00A5, k));
         end
         n_cmp++;
         if ({memfifo_data_ready, xfer_done} !== ((k == 5) ? 2'b01 : 2'b10)) begin
            n_bad++;
            $display("FAIL basic_done: word %0d ready/done got %b want %b", k,
                     {memfifo_data_ready, xfer_done}, (k == 5) ? 2'b01 : 2'b10);
         end
         if (k == 0) begin
            n_cmp++;
            if (memfifo_data !== 64'h00A5_0000_0000_0000) begin
               n_bad++;
               $display("FAIL basic_first_word: got %h want 00a5000000000000", memfifo_data);
            end
         end
         if (k == 5) begin
            n_cmp++;
            if (memfifo_data !== 64'h00A5_0002_0001_0005) begin
               n_bad++;
               $display("FAIL basic_last_word: got %h want 00a5000200010005", memfifo_data);
            end
         end
      end
      tick();
      n_cmp++;
      if ({memfifo_data_valid, xfer_done, err_underrun, err_busy_req} !== 4'b0) begin
         n_bad++;
         $display("FAIL basic_after: valid/done/ur/busy got %b want 0000",
                  {memfifo_data_valid, xfer_done, err_underrun, err_busy_req});
      end
   endtask

   task automatic test_zero_packets();
      logic [15:0] tag;
      tag = 16'($urandom);
      start_req(tag, 16'd0);
      repeat (FD - 1) tick();
      n_cmp++;
      if (memfifo_data_ready !== 1'b0 || memfifo_packet_no !== 16'd3) begin
         n_bad++;
         $display("FAIL zero_fetch_hold: got ready=%0b pn=%0d want 0 3", memfifo_data_ready,
                  memfifo_packet_no);
      end
      tick();
      n_cmp++;
      if (memfifo_data_ready !== 1'b1 || memfifo_packet_no !== 16'd0 ||
          memfifo_data_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_ready: got ready=%0b pn=%0d valid=%0b want 1 0 0",
                  memfifo_data_ready, memfifo_packet_no, memfifo_data_valid);
      end
      tick();
      n_cmp++;
      if ({memfifo_data_ready, xfer_done, memfifo_data_valid} !== 3'b010) begin
         n_bad++;
         $display("FAIL zero_done: ready/done/valid got %b want 010",
                  {memfifo_data_ready, xfer_done, memfifo_data_valid});
      end
      tick();
      n_cmp++;
      if ({xfer_done, memfifo_data_valid, err_underrun, err_busy_req} !== 4'b0) begin
         n_bad++;
         $display("FAIL zero_after: done/valid/ur/busy got %b want 0000",
                  {xfer_done, memfifo_data_valid, err_underrun, err_busy_req});
      end
   endtask

   task automatic test_back_to_back(output logic [15:0] tag_used);
      logic [15:0] tag;
      tag      = 16'($urandom);
      tag_used = tag;
      start_req(tag, 16'd2);
      repeat (FD) tick();
      n_cmp++;
      if (memfifo_data_ready !== 1'b1 || memfifo_packet_no !== 16'd2) begin
         n_bad++;
         $display("FAIL b2b_ready: got ready=%0b pn=%0d want 1 2", memfifo_data_ready,
                  memfifo_packet_no);
      end
      repeat ($urandom_range(0, 3)) tick();
      memfifo_re = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         n_cmp++;
         if (memfifo_data_valid !== 1'b1 || memfifo_data !== exp_word(tag, j)) begin
            n_bad++;
            $display("FAIL b2b_word: word %0d got valid=%0b data=%h want 1 %h", j,
                     memfifo_data_valid, memfifo_data, exp_word(tag, j));
         end
         n_cmp++;
         if ({memfifo_data_ready, xfer_done} !== ((j == 3) ? 2'b01 : 2'b10)) begin
            n_bad++;
            $display("FAIL b2b_ready_done: word %0d got %b want %b", j,
                     {memfifo_data_ready, xfer_done}, (j == 3) ? 2'b01 : 2'b10);
         end
      end
      memfifo_re = 1'b0;
      tick();
      n_cmp++;
      if ({memfifo_data_valid, memfifo_data_ready, err_underrun} !== 3'b0) begin
         n_bad++;
         $display("FAIL b2b_after: valid/ready/ur got %b want 000",
                  {memfifo_data_valid, memfifo_data_ready, err_underrun});
      end
   endtask

   task automatic test_underrun(input logic [15:0] prev_tag);
      logic [15:0] tag;
      memfifo_re = 1'b1;
      tick();
      memfifo_re = 1'b0;
      n_cmp++;
      if (err_underrun !== 1'b1 || memfifo_data_valid !== 1'b0 ||
          memfifo_data !== exp_word(prev_tag, 3)) begin
         n_bad++;
         $display("FAIL underrun_idle: got ur=%0b valid=%0b data=%h want 1 0 %h", err_underrun,
                  memfifo_data_valid, memfifo_data, exp_word(prev_tag, 3));
      end
      apply_reset();
      n_cmp++;
      if (err_underrun !== 1'b0) begin
         n_bad++;
         $display("FAIL underrun_reset_clear: got %0b want 0", err_underrun);
      end
      tag = 16'($urandom);
      start_req(tag, 16'd1);
      repeat (3) tick();
      memfifo_re = 1'b1;
      tick();
      memfifo_re = 1'b0;
      n_cmp++;
      if (err_underrun !== 1'b1 || memfifo_data_valid !== 1'b0 || memfifo_data !== '0) begin
         n_bad++;
         $display("FAIL underrun_fetch: got ur=%0b valid=%0b data=%h want 1 0 0", err_underrun,
                  memfifo_data_valid, memfifo_data);
      end
      repeat (FD - 4) tick();
      n_cmp++;
      if (memfifo_data_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL underrun_fetch_ready: got %0b want 1", memfifo_data_ready);
      end
      memfifo_re = 1'b1;
      for (int j = 0; j < 2; j++) begin
         tick();
         n_cmp++;
         if (memfifo_data_valid !== 1'b1 || memfifo_data !== exp_word(tag, j)) begin
            n_bad++;
            $display("FAIL underrun_serve: word %0d got valid=%0b data=%h want 1 %h", j,
                     memfifo_data_valid, memfifo_data, exp_word(tag, j));
         end
      end
      memfifo_re = 1'b0;
      tick();
   endtask

   task automatic test_busy_request();
      logic [15:0] tag_a;
      logic [15:0] pn_a;
      int          g;
      apply_reset();
      tag_a = 16'($urandom);
      pn_a  = 16'($urandom_range(1, 3));
      g     = int'($urandom_range(2, FD - 2));
      start_req(tag_a, pn_a);
      for (int i = 1; i <= int'(FD); i++) begin
         if (i == g) begin
            req_tag       = ~tag_a;
            req_packet_no = pn_a + 16'd5;
            data_req      = 1'b1;
         end
         tick();
         data_req = 1'b0;
         n_cmp++;
         if (memfifo_data_ready !== 1'(i == int'(FD))) begin
            n_bad++;
            $display("FAIL busy_ready_timing: cycle %0d got %0b want %0b", i,
                     memfifo_data_ready, (i == int'(FD)));
         end
         if (i == g) begin
            n_cmp++;
            if (err_busy_req !== 1'b1) begin
               n_bad++;
               $display("FAIL busy_flag: got %0b want 1", err_busy_req);
            end
         end
      end
      n_cmp++;
      if (memfifo_packet_no !== pn_a) begin
         n_bad++;
         $display("FAIL busy_packet_no: got %0d want %0d", memfifo_packet_no, pn_a);
      end
      for (int n = 0; n < int'(pn_a) * int'(WPP); n++) begin
         repeat ($urandom_range(0, 4)) tick();
         memfifo_re = 1'b1;
         tick();
         memfifo_re = 1'b0;
         n_cmp++;
         if (memfifo_data_valid !== 1'b1 || memfifo_data !== exp_word(tag_a, n)) begin
            n_bad++;
            $display("FAIL busy_word: word %0d got valid=%0b data=%h want 1 %h", n,
                     memfifo_data_valid, memfifo_data, exp_word(tag_a, n));
         end
         n_cmp++;
         if (xfer_done !== 1'(n == int'(pn_a) * int'(WPP) - 1)) begin
            n_bad++;
            $display("FAIL busy_done: word %0d got %0b", n, xfer_done);
         end
      end
      tick();
      n_cmp++;
      if ({err_busy_req, err_underrun, memfifo_data_ready} !== 3'b100) begin
         n_bad++;
         $display("FAIL busy_flags_end: busy/ur/ready got %b want 100",
                  {err_busy_req, err_underrun, memfifo_data_ready});
      end
   endtask

   task automatic test_reset_mid_transfer();
      logic [15:0] tag;
      logic [15:0] tag2;
      apply_reset();
      tag = 16'($urandom);
      start_req(tag, 16'd3);
      repeat (FD) tick();
      memfifo_re = 1'b1;
      tick();
      tick();
      memfifo_re = 1'b0;
      n_cmp++;
      if (memfifo_data !== exp_word(tag, 1)) begin
         n_bad++;
         $display("FAIL mid_pre_reset: got %h want %h", memfifo_data, exp_word(tag, 1));
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({memfifo_data_ready, memfifo_packet_no, memfifo_data, memfifo_data_valid, xfer_done,
           err_underrun, err_busy_req} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset_outputs: got ready=%0b pn=%h data=%h valid=%0b done=%0b ur=%0b busy=%0b want all 0",
                  memfifo_data_ready, memfifo_packet_no, memfifo_data, memfifo_data_valid,
                  xfer_done, err_underrun, err_busy_req);
      end
      tick();
      rst_n = 1'b1;
      tag2 = 16'($urandom);
      start_req(tag2, 16'd1);
      repeat (FD) tick();
      n_cmp++;
      if (memfifo_data_ready !== 1'b1 || memfifo_packet_no !== 16'd1) begin
         n_bad++;
         $display("FAIL mid_new_ready: got ready=%0b pn=%0d want 1 1", memfifo_data_ready,
                  memfifo_packet_no);
      end
      memfifo_re = 1'b1;
      for (int j = 0; j < 2; j++) begin
         tick();
         n_cmp++;
         if (memfifo_data_valid !== 1'b1 || memfifo_data !== exp_word(tag2, j) ||
             xfer_done !== 1'(j == 1)) begin
            n_bad++;
            $display("FAIL mid_new_word: word %0d got valid=%0b data=%h done=%0b want 1 %h %0b",
                     j, memfifo_data_valid, memfifo_data, xfer_done, exp_word(tag2, j), (j == 1));
         end
      end
      memfifo_re = 1'b0;
      tick();
   endtask

   initial begin
      logic [15:0] b2b_tag;
      test_reset();
      test_basic();
      test_zero_packets();
      test_back_to_back(b2b_tag);
      test_underrun(b2b_tag);
      test_busy_request();
      test_reset_mid_transfer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
